// File: rtl/pq_drain_sequencer.sv
// Batch drain sequencer for a priority queue read port.
// Pops i_count entries, buffers them and streams them out with order checks.
module pq_drain_sequencer #(
  parameter int QUEUE_DEPTH = 10,
  parameter int DATA_LENGTH = 32,
  parameter int BUF_DEPTH = 2,
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_start,
  input  logic [CNT_W-1:0]       i_count,
  input  logic                   i_abort,
  input  logic                   pq_empty,
  output logic                   pq_rd_req,
  input  logic                   pq_data_valid,
  input  logic [DATA_LENGTH-1:0] pq_data,
  output logic                   o_valid,
  output logic [DATA_LENGTH-1:0] o_data,
  input  logic                   i_ready,
  output logic [CNT_W-1:0]       o_remaining,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_order_err,
  output logic                   o_underflow_err
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0] remaining, rem_n;
  logic [DATA_LENGTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [OCC_W-1:0] occ;
  logic [DATA_LENGTH-1:0] last_val;
  logic have_last;
  logic order_err, underflow_err;

  logic issue, push, pop, flush;
  logic clr_err, set_uf, viol;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    state_n = state;
    rem_n = remaining;
    issue = 1'b0;
    push = 1'b0;
    flush = 1'b0;
    clr_err = 1'b0;
    set_uf = 1'b0;
    // Abort overrides every state action, including a same-cycle response.
    if (i_abort && state != S_IDLE) begin
      state_n = S_IDLE;
      rem_n = '0;
      flush = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            clr_err = 1'b1;
            rem_n = i_count;
            state_n = (i_count != '0) ? S_ISSUE : S_DONE;
          end
        end
        S_ISSUE: begin
          if (remaining == '0) begin
            state_n = S_DRAIN;
          end else if (!pq_empty && occ < FULL) begin
            issue = 1'b1;
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          state_n = S_ISSUE;
          if (pq_data_valid) begin
            push = 1'b1;
            rem_n = remaining - CNT_W'(1);
          end else begin
            set_uf = 1'b1;
          end
        end
        S_DRAIN: begin
          if (occ == '0) state_n = S_DONE;
        end
        S_DONE: state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign pop = o_valid && i_ready && !flush;
  assign viol = push && have_last && (pq_data < last_val);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      remaining <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ <= '0;
      last_val <= '0;
      have_last <= 1'b0;
      order_err <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      state <= state_n;
      remaining <= rem_n;
      if (clr_err) begin
        order_err <= 1'b0;
        underflow_err <= 1'b0;
        have_last <= 1'b0;
      end else begin
        if (viol) order_err <= 1'b1;
        if (set_uf) underflow_err <= 1'b1;
        if (push) begin
          last_val <= pq_data;
          have_last <= 1'b1;
        end
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ <= '0;
      end else begin
        if (push) wr_ptr <= nxt(wr_ptr);
        if (pop) rd_ptr <= nxt(rd_ptr);
        unique case ({push, pop})
          2'b10: occ <= occ + OCC_W'(1);
          2'b01: occ <= occ - OCC_W'(1);
          default: occ <= occ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= pq_data;
  end

  assign pq_rd_req = issue;
  assign o_valid = (occ != '0);
  assign o_data = o_valid ? mem[rd_ptr] : '0;
  assign o_remaining = remaining;
  assign o_busy = (state != S_IDLE);
  assign o_done = (state == S_DONE);
  assign o_order_err = order_err;
  assign o_underflow_err = underflow_err;

endmodule

// File: tb/tb_pq_drain_sequencer.sv
// Bench for pq_drain_sequencer: queue responder, batch-level model, directed
// cases and randomized batches.
module tb_pq_drain_sequencer;
  localparam int BD = 2;

  logic clk = 1'b0;
  logic RST, i_start, i_abort, pq_empty, pq_rd_req;
  logic pq_data_valid, o_valid, i_ready, o_busy, o_done;
  logic o_order_err, o_underflow_err;
  logic [3:0] i_count, o_remaining;
  logic [31:0] pq_data, o_data;

  pq_drain_sequencer #(.QUEUE_DEPTH(10), .DATA_LENGTH(32), .BUF_DEPTH(BD)) dut (
    .CLK(clk), .RST(RST), .i_start(i_start), .i_count(i_count),
    .i_abort(i_abort), .pq_empty(pq_empty), .pq_rd_req(pq_rd_req),
    .pq_data_valid(pq_data_valid), .pq_data(pq_data), .o_valid(o_valid),
    .o_data(o_data), .i_ready(i_ready), .o_remaining(o_remaining),
    .o_busy(o_busy), .o_done(o_done), .o_order_err(o_order_err),
    .o_underflow_err(o_underflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] pq[$];
  bit unsorted = 0, lie_empty = 0, force_invalid = 0;
  bit req_seen = 0, armed = 0;

  bit m_act = 0, m_out = 0, m_have = 0, m_oe = 0, m_uf = 0, exp_req = 0;
  int m_rem = 0, done_wait = 0;
  logic [31:0] m_last = 0;
  logic [31:0] m_fifo[$];

  logic [31:0] outlog[$];
  int done_cnt = 0, req_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] take();
    int k = 0;
    logic [31:0] v;
    if (!unsorted)
      for (int j = 1; j < pq.size(); j++)
        if (pq[j] < pq[k]) k = j;
    v = pq[k];
    pq.delete(k);
    return v;
  endfunction

  task automatic check_cycle();
    bit cond;
    exp_req = m_act && !m_out && m_rem > 0 && !pq_empty &&
              m_fifo.size() < BD && !i_abort;
    if (!armed) return;
    chk("busy", o_busy, m_act);
    chk("remaining", o_remaining, m_rem);
    chk("order_err", o_order_err, m_oe);
    chk("underflow_err", o_underflow_err, m_uf);
    chk("valid", o_valid, m_fifo.size() != 0);
    if (o_valid && m_fifo.size() != 0) chk("data", o_data, m_fifo[0]);
    chk("rd_req", pq_rd_req, exp_req);
    cond = m_act && m_rem == 0 && m_fifo.size() == 0;
    if (o_done) begin
      done_cnt++;
      chk("done_legal", o_done, cond);
    end
    if (cond) begin
      if (done_wait >= 2) chk("done_late", o_done, 1);
      done_wait++;
    end else begin
      done_wait = 0;
    end
    if (o_valid && i_ready) outlog.push_back(o_data);
    if (pq_rd_req) req_cnt++;
  endtask

  task automatic model_update();
    if (RST) begin
      m_act = 0; m_out = 0; m_rem = 0; m_have = 0;
      m_oe = 0; m_uf = 0; done_wait = 0;
      m_fifo.delete();
    end else if (m_act && i_abort) begin
      m_act = 0; m_out = 0; m_rem = 0;
      m_fifo.delete();
    end else begin
      if (m_fifo.size() != 0 && i_ready) void'(m_fifo.pop_front());
      if (m_out) begin
        if (pq_data_valid) begin
          if (m_have && pq_data < m_last) m_oe = 1;
          m_last = pq_data;
          m_have = 1;
          m_fifo.push_back(pq_data);
          m_rem--;
        end else begin
          m_uf = 1;
        end
        m_out = 0;
      end
      if (exp_req) m_out = 1;
      if (!m_act && i_start) begin
        m_act = 1; m_rem = i_count;
        m_oe = 0; m_uf = 0; m_have = 0;
      end else if (m_act && o_done) begin
        m_act = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    pq_empty = lie_empty ? 1'b0 : (pq.size() == 0);
    #1;
    check_cycle();
    model_update();
    req_seen = armed ? exp_req : 1'b0;
    @(posedge clk);
    #1;
    armed = 1;
    if (req_seen) begin
      if (force_invalid || pq.size() == 0) begin
        pq_data_valid = 0;
        pq_data = $urandom;
        force_invalid = 0;
      end else begin
        pq_data_valid = 1;
        pq_data = take();
      end
    end else begin
      pq_data_valid = 0;
      pq_data = $urandom;
    end
  endtask

  task automatic start_batch(input int cnt);
    i_start = 1;
    i_count = 4'(cnt);
    tick();
    i_start = 0;
  endtask

  task automatic wait_idle(input int budget, input bit must);
    int n = 0;
    while (m_act && n < budget) begin
      tick();
      n++;
    end
    if (m_act) begin
      if (must) chk("batch_timeout", m_act, 0);
      i_abort = 1;
      tick();
      i_abort = 0;
    end
  endtask

  task automatic expect_log(input string nm, input logic [31:0] e[$]);
    chk({nm, "_len"}, outlog.size(), e.size());
    for (int j = 0; j < e.size() && j < outlog.size(); j++)
      chk(nm, outlog[j], e[j]);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0;
    logic [31:0] e[$];
    RST = 1; i_start = 0; i_count = 0; i_abort = 0; i_ready = 1;
    pq_empty = 1; pq_data_valid = 0; pq_data = 0;
    repeat (3) tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_remaining", o_remaining, 0);
    chk("rst_rd_req", pq_rd_req, 0);
    chk("rst_errs", {o_order_err, o_underflow_err}, 0);
    RST = 0;
    tick();

    // sorted drain of a full queue
    pq = '{32'd12, 32'd1, 32'd2, 32'd14, 32'd12, 32'd3, 32'd0, 32'd20, 32'd25, 32'd13};
    outlog.delete(); d0 = done_cnt;
    start_batch(10);
    wait_idle(200, 1);
    e = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd12, 32'd12, 32'd13, 32'd14, 32'd20, 32'd25};
    expect_log("t1_data", e);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_errs", {o_order_err, o_underflow_err}, 0);

    // backpressure: only BUF_DEPTH requests while stalled
    pq = '{32'd12, 32'd1, 32'd2, 32'd14, 32'd12, 32'd3, 32'd0, 32'd20, 32'd25, 32'd13};
    outlog.delete(); i_ready = 0; r0 = req_cnt;
    start_batch(10);
    repeat (20) tick();
    chk("t2_reqs", req_cnt - r0, BD);
    chk("t2_valid", o_valid, 1);
    chk("t2_head", o_data, 0);
    i_ready = 1;
    wait_idle(200, 1);
    expect_log("t2_data", e);

    // starved batch, then abort
    pq = '{32'd7};
    outlog.delete();
    start_batch(3);
    repeat (12) tick();
    chk("t3_remaining", o_remaining, 2);
    chk("t3_rd_req", pq_rd_req, 0);
    chk("t3_outs", outlog.size(), 1);
    chk("t3_busy", o_busy, 1);
    d0 = done_cnt;
    i_abort = 1;
    tick();
    i_abort = 0;
    chk("t3_abort_busy", o_busy, 0);
    repeat (2) tick();
    chk("t3_no_done", done_cnt - d0, 0);

    // out-of-order data from the queue
    unsorted = 1;
    pq = '{32'd5, 32'd3};
    outlog.delete();
    start_batch(2);
    wait_idle(100, 1);
    expect_log("t4_data", '{32'd5, 32'd3});
    chk("t4_order_err", o_order_err, 1);
    start_batch(0);
    chk("t4_cleared", o_order_err, 0);
    wait_idle(10, 1);
    unsorted = 0;

    // underflow response is retried
    pq = '{32'd9, 32'd4};
    outlog.delete(); r0 = req_cnt; force_invalid = 1;
    start_batch(2);
    wait_idle(100, 1);
    chk("t5_underflow", o_underflow_err, 1);
    chk("t5_reqs", req_cnt - r0, 3);
    expect_log("t5_data", '{32'd4, 32'd9});

    // reset while a response is in flight
    pq = '{32'd8, 32'd9};
    start_batch(2);
    for (int n = 0; n < 10 && !req_seen; n++) tick();
    chk("t6_req_seen", req_seen, 1);
    RST = 1;
    tick();
    RST = 0;
    chk("t6_outs", {o_valid, o_busy, o_done, o_order_err, o_underflow_err}, 0);
    chk("t6_data", o_data, 0);
    chk("t6_remaining", o_remaining, 0);
    tick();
    chk("t6_valid_low", o_valid, 0);
    pq.delete();
    start_batch(0);
    chk("t6_done", o_done, 1);
    wait_idle(10, 1);

    // randomized batches
    for (int b = 0; b < 40; b++) begin
      int n, cnt, k;
      bit feasible;
      pq.delete();
      n = $urandom_range(0, 10);
      for (int j = 0; j < n; j++)
        pq.push_back(($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40));
      cnt = $urandom_range(0, 10);
      force_invalid = ($urandom_range(0, 4) == 0);
      feasible = (cnt <= n);
      i_ready = ($urandom_range(0, 3) != 0);
      start_batch(cnt);
      k = 0;
      while (m_act && k < 300) begin
        i_ready = ($urandom_range(0, 3) != 0);
        i_abort = ($urandom_range(0, 79) == 0);
        i_start = ($urandom_range(0, 15) == 0);
        i_count = 4'($urandom_range(0, 10));
        if (i_abort) feasible = 0;
        tick();
        k++;
      end
      i_abort = 0; i_start = 0;
      wait_idle(1, feasible);
      force_invalid = 0;
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
